wptr_full_ctrl: RTL
===================

// Module: wptr_full_ctrl
// PURPOSE
//  Write-domain controller of the PCS TX async FIFO: owns the write pointer and the write-side status flags.
//  Takes the read pointer after its 2-flop sync into wclk (wq2_rptr) and produces:
//  - the RAM write address and the Gray write pointer sent to the read domain;
//  - the full, almost-full, fill-level and sticky-overflow status.
// PARAMETERS
//  ADDRSIZE     7  FIFO address width; depth = 2**ADDRSIZE entries (128); ADDRSIZE >= 2
//  AFULL_THRESH 8  wafull asserts when free entries <= AFULL_THRESH; range 1..2**ADDRSIZE-1
// PORTS
//  wclk      in   1           write clock
//  wrst_n    in   1           reset, asynchronous, active-low
//  winc      in   1           write request; accepted only when wfull==0
//  wq2_rptr  in   ADDRSIZE+1  read pointer (Gray), already synchronised into wclk
//  wovf_clr  in   1           clears wovf
//  waddr     out  ADDRSIZE    RAM write address = wbin[ADDRSIZE-1:0]
//  wptr      out  ADDRSIZE+1  registered Gray write pointer, to the r-domain synchroniser
//  wfull     out  1           FIFO full, registered
//  wafull    out  1           almost full, registered
//  wlevel    out  ADDRSIZE+1  fill level seen from the write side, 0..2**ADDRSIZE, registered
//  wovf      out  1           sticky flag: a write was attempted while full
// BEHAVIOUR
//  - Reset (async, wrst_n=0): wbin=0, wptr=0, wfull=0, wafull=0, wlevel=0, wovf=0.
//    waddr is therefore 0. Reset mid-operation discards all pointer state immediately.
//  - wbin is an ADDRSIZE+1 binary counter.
//    wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1). This gives natural wrap-around.
//  - wgraynext = (wbinnext>>1) ^ wbinnext. wbin and wptr both load on every wclk edge.
//    Only one bit of wptr changes per accepted write.
//  - Write strobe to RAM = winc & ~wfull, at address waddr, in the same cycle the write is accepted.
//  - wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
//    It is registered, so wfull is valid in the cycle after the filling write.
//  - rbin = Gray-to-binary of wq2_rptr (XOR prefix from the MSB), combinational.
//  - wlevel_next = wbinnext - rbin, modulo 2**(ADDRSIZE+1). It is registered into wlevel.
//  - wafull_next = (wlevel_next >= 2**ADDRSIZE - AFULL_THRESH). It is registered.
//  - The flags are pessimistic. After the read side advances, wfull, wafull and wlevel update one wclk
//    after wq2_rptr changes (3+ wclk after the r-domain move). They never report more free space than exists.
//  - Write while full (winc=1, wfull=1): pointers, waddr and wlevel are unchanged, no RAM strobe, wovf set to 1.
//  - wovf is cleared by wovf_clr=1. If set and clear occur in the same cycle, set wins and wovf stays 1.
//  - Simultaneous accepted write and read-pointer advance: level is net unchanged, and wfull cannot assert.
//  - wq2_rptr is trusted as Gray-valid. No checking is done on it.
// TESTING
//  1. Hold wrst_n=0, drive winc=1 -> wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0, wovf=0.
//     Release wrst_n -> first write goes to waddr 0.
//  2. wq2_rptr=0, 128 consecutive winc -> wafull=1 the cycle after write #120 (wlevel=120).
//     Then wfull=1 the cycle after write #128, with wlevel=128, wptr=8'hC0, waddr=0.
//  3. Full, winc=1 for 3 cycles -> wptr stays 8'hC0, wlevel stays 128, wovf=1.
//     Then wovf_clr=1 together with winc=1 -> wovf stays 1. wovf_clr alone -> wovf=0.
//  4. Full, set wq2_rptr=8'h01 (rbin=1) -> next cycle wfull=0, wlevel=127, wafull=1.
//     One write -> wfull=1 again, wptr=8'hC1.
//  5. Write 300 entries with wq2_rptr tracking gray(wbin-4) each cycle -> wlevel stays 4, wfull never asserts.
//     Across the 255->0 wrap, wptr goes 8'h80 -> 8'h00 with a single-bit change.
//  6. Assert wrst_n=0 asynchronously mid-burst (wlevel=50) -> all outputs 0 before the next wclk edge.
//     The first write after release goes to waddr 0.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer owner for the async FIFO.
// Produces the RAM write address, the Gray write pointer and the full/almost-full/level/overflow flags.
module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 7,
  parameter int AFULL_THRESH = 8
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);
  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'((1 << ADDRSIZE) - AFULL_THRESH);
  logic [ADDRSIZE:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin;
  logic wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wovf_d, wen;
  always_comb begin
    rbin = '0;
    wen = winc & ~wfull_q;
    wbin_d = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    wptr_d = (wbin_d >> 1) ^ wbin_d;
    for (int i = 0; i <= ADDRSIZE; i++) rbin[i] = ^(wq2_rptr >> i);
    // full when the next write pointer has lapped the read pointer by exactly one depth
    wfull_d = wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wlevel_d = wbin_d - rbin;
    wafull_d = wlevel_d >= AFULL_LVL;
    wovf_d = (winc & wfull_q) | (wovf_q & ~wovf_clr);
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q <= '0;
      wptr_q <= '0;
      wlevel_q <= '0;
      wfull_q <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q <= wovf_d;
    end
  end
  assign waddr = wbin_q[ADDRSIZE-1:0];
  assign wptr = wptr_q;
  assign wfull = wfull_q;
  assign wafull = wafull_q;
  assign wlevel = wlevel_q;
  assign wovf = wovf_q;
endmodule
